// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle for the elastic pipeline-stage register
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  // Surrounding pipeline side: drives upstream payload, downstream ready and flush
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  // Stage side
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline-stage register with two-entry skid, flush and bubbles (optional PIPE_STAGE_ZERO_BUBBLE_EN)
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  pipe_stage_reg_if.slave bus
);

  // Encoding equals the number of held entries, so occupancy is the state itself
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;

  logic in_ready_w;
  logic out_valid_w;
  logic in_fire;
  logic out_fire;

  // Handshake outputs come from registered state only; no combinational ready path
  assign in_ready_w  = (state_q != FULL);
  assign out_valid_w = (state_q != EMPTY);
  assign in_fire     = bus.in_valid & in_ready_w;
  assign out_fire    = out_valid_w & bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = m_q;
  assign bus.occupancy = state_q;

  // State and payload registers; reset forces bubbles into both entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      m_q     <= NOP_VALUE;
      s_q     <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Next-state and payload steering; flush overrides everything else
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          m_d = bus.in_data;
        end else if (in_fire) begin
          s_d     = bus.in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
          m_d = NOP_VALUE;
`endif
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = BUSY;
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
          s_d = NOP_VALUE;
`endif
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // An input accepted in the flush cycle is dropped along with held entries
    if (bus.flush) begin
      state_d = EMPTY;
`ifdef PIPE_STAGE_ZERO_BUBBLE_EN
      m_d = NOP_VALUE;
      s_d = NOP_VALUE;
`endif
    end
  end

endmodule
